cond_logic: RTL and testbench



---
 rtl/cond_pkg.sv | 31 +++
 rtl/cond_logic_if.sv | 30 +++
 rtl/cond_check.sv | 42 ++++
 rtl/cond_logic.sv | 57 +++++
 tb/tb_cond_logic.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/cond_pkg.sv
// Shared constants for the condition-check / enable-gating block:
// widths, ARM condition encodings and flag bit positions.
package cond_pkg;

    localparam int FLAG_W = 4;
    localparam int COND_W = 4;

    // Flag bit positions inside {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [COND_W-1:0] COND_EQ  = 4'b0000;
    localparam logic [COND_W-1:0] COND_NE  = 4'b0001;
    localparam logic [COND_W-1:0] COND_CS  = 4'b0010;
    localparam logic [COND_W-1:0] COND_CC  = 4'b0011;
    localparam logic [COND_W-1:0] COND_MI  = 4'b0100;
    localparam logic [COND_W-1:0] COND_PL  = 4'b0101;
    localparam logic [COND_W-1:0] COND_VS  = 4'b0110;
    localparam logic [COND_W-1:0] COND_VC  = 4'b0111;
    localparam logic [COND_W-1:0] COND_HI  = 4'b1000;
    localparam logic [COND_W-1:0] COND_LS  = 4'b1001;
    localparam logic [COND_W-1:0] COND_GE  = 4'b1010;
    localparam logic [COND_W-1:0] COND_LT  = 4'b1011;
    localparam logic [COND_W-1:0] COND_GT  = 4'b1100;
    localparam logic [COND_W-1:0] COND_LE  = 4'b1101;
    localparam logic [COND_W-1:0] COND_AL  = 4'b1110;
    localparam logic [COND_W-1:0] COND_RSV = 4'b1111;

endpackage

// File: rtl/cond_logic_if.sv
// Controller <-> cond_logic signal bundle. The controller/decoder side is
// the master; cond_logic is the slave that returns the gated enables.
interface cond_logic_if;
    import cond_pkg::*;

    logic [COND_W-1:0] Cond;
    logic [FLAG_W-1:0] ALUFlags;
    logic [1:0]        FlagW;
    logic              dec_valid;
    logic              PCS;
    logic              NextPC;
    logic              RegW;
    logic              MemW;
    logic              PCWrite;
    logic              RegWrite;
    logic              MemWrite;
    logic [FLAG_W-1:0] Flags;
    logic              CondEx;

    modport master (
        output Cond, ALUFlags, FlagW, dec_valid, PCS, NextPC, RegW, MemW,
        input  PCWrite, RegWrite, MemWrite, Flags, CondEx
    );

    modport slave (
        input  Cond, ALUFlags, FlagW, dec_valid, PCS, NextPC, RegW, MemW,
        output PCWrite, RegWrite, MemWrite, Flags, CondEx
    );

endinterface

// File: rtl/cond_check.sv
// Combinational ARM condition-field evaluator against a {N,Z,C,V} flag set.
// The reserved encoding evaluates to 0 so no X can leak into CondEx.
module cond_check
    import cond_pkg::*;
(
    input  logic [COND_W-1:0] cond_i,
    input  logic [FLAG_W-1:0] flags_i,
    output logic              cond_ok_o
);

    logic n, z, c, v;

    assign n = flags_i[FLAG_N];
    assign z = flags_i[FLAG_Z];
    assign c = flags_i[FLAG_C];
    assign v = flags_i[FLAG_V];

    // Decode the condition field into a pass/fail bit
    always_comb begin
        cond_ok_o = 1'b0;
        case (cond_i)
            COND_EQ:  cond_ok_o = z;
            COND_NE:  cond_ok_o = ~z;
            COND_CS:  cond_ok_o = c;
            COND_CC:  cond_ok_o = ~c;
            COND_MI:  cond_ok_o = n;
            COND_PL:  cond_ok_o = ~n;
            COND_VS:  cond_ok_o = v;
            COND_VC:  cond_ok_o = ~v;
            COND_HI:  cond_ok_o = c & ~z;
            COND_LS:  cond_ok_o = ~c | z;
            COND_GE:  cond_ok_o = (n == v);
            COND_LT:  cond_ok_o = (n != v);
            COND_GT:  cond_ok_o = ~z & (n == v);
            COND_LE:  cond_ok_o = z | (n != v);
            COND_AL:  cond_ok_o = 1'b1;
            COND_RSV: cond_ok_o = 1'b0;
            default:  cond_ok_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Architectural flag register plus condition latch for the multicycle
// controller. CondEx is captured at decode and gates the PC, register-file,
// memory and flag write enables one cycle later. Condition evaluation only
// ever looks at the registered flags; there is no forwarding from ALUFlags.
module cond_logic
    import cond_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    cond_logic_if.slave   bus
);

    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              cond_ex_q, cond_ex_d;
    logic              cond_ok;
    logic [1:0]        flag_write;

    cond_check u_cond_check (
        .cond_i    (bus.Cond),
        .flags_i   (flags_q),
        .cond_ok_o (cond_ok)
    );

    // Next-state: half-word flag loads gated by CondEx, CondEx reloaded on decode
    always_comb begin
        flag_write = bus.FlagW & {2{cond_ex_q}};
        flags_d    = flags_q;
        if (flag_write[1]) begin
            flags_d[FLAG_N] = bus.ALUFlags[FLAG_N];
            flags_d[FLAG_Z] = bus.ALUFlags[FLAG_Z];
        end
        if (flag_write[0]) begin
            flags_d[FLAG_C] = bus.ALUFlags[FLAG_C];
            flags_d[FLAG_V] = bus.ALUFlags[FLAG_V];
        end
        cond_ex_d = bus.dec_valid ? cond_ok : cond_ex_q;
    end

    // State registers; reset wins over decode and flag writes
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags_q   <= '0;
            cond_ex_q <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex_d;
        end
    end

    // Enable gating; the fetch PC write is never masked
    assign bus.PCWrite  = (bus.PCS & cond_ex_q) | bus.NextPC;
    assign bus.RegWrite = bus.RegW & cond_ex_q;
    assign bus.MemWrite = bus.MemW & cond_ex_q;
    assign bus.Flags    = flags_q;
    assign bus.CondEx   = cond_ex_q;

endmodule

// File: tb/tb_cond_logic.sv
// Bench for cond_logic: directed walk-through of the key scenarios followed
// by randomized traffic, all checked against a behavioural reference model.
module tb_cond_logic;

    logic clk;
    logic reset_n;

    cond_logic_if cif ();

    cond_logic dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (cif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference state: what the flag register and CondEx should hold
    logic [3:0] m_flags;
    logic       m_cx;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ARM-style evaluation: even codes give the base test, odd codes invert it
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        if (c == 4'hF) return 1'b0;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    // One clock: check outputs mid-cycle, advance the model, land just past the edge
    task automatic cycle();
        logic [3:0] nf;
        @(negedge clk);
        chk("Flags",    {28'd0, cif.Flags},    {28'd0, m_flags});
        chk("CondEx",   {31'd0, cif.CondEx},   {31'd0, m_cx});
        chk("PCWrite",  {31'd0, cif.PCWrite},  {31'd0, (cif.PCS & m_cx) | cif.NextPC});
        chk("RegWrite", {31'd0, cif.RegWrite}, {31'd0, cif.RegW & m_cx});
        chk("MemWrite", {31'd0, cif.MemWrite}, {31'd0, cif.MemW & m_cx});
        if (!reset_n) begin
            m_flags = 4'b0000;
            m_cx    = 1'b0;
        end else begin
            nf = m_flags;
            if (cif.FlagW[1] && m_cx) nf[3:2] = cif.ALUFlags[3:2];
            if (cif.FlagW[0] && m_cx) nf[1:0] = cif.ALUFlags[1:0];
            if (cif.dec_valid) m_cx = ref_cond(cif.Cond, m_flags);
            m_flags = nf;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] c, input logic dv, input logic [1:0] fw,
                         input logic [3:0] af);
        cif.Cond      = c;
        cif.dec_valid = dv;
        cif.FlagW     = fw;
        cif.ALUFlags  = af;
    endtask

    // Decode one condition with no flag write and check the latched result
    task automatic decode_chk(input string tag, input logic [3:0] c, input logic exp);
        drive(c, 1'b1, 2'b00, 4'h0);
        cycle();
        chk(tag, {31'd0, cif.CondEx}, {31'd0, exp});
    endtask

    // Force the flag register to a value via an AL decode then a full write
    task automatic load_flags(input logic [3:0] f);
        drive(4'b1110, 1'b1, 2'b00, 4'h0);
        cycle();
        drive(4'b1110, 1'b0, 2'b11, f);
        cycle();
    endtask

    initial begin
        reset_n       = 1'b0;
        cif.PCS       = 1'b1;
        cif.NextPC    = 1'b0;
        cif.RegW      = 1'b1;
        cif.MemW      = 1'b1;
        drive(4'b1110, 1'b1, 2'b11, 4'b1111);
        m_flags = 4'b0000;
        m_cx    = 1'b0;
        @(posedge clk);
        #1;

        // Reset held: registers cleared, only NextPC reaches PCWrite
        chk("rst_flags",  {28'd0, cif.Flags},  32'd0);
        chk("rst_condex", {31'd0, cif.CondEx}, 32'd0);
        chk("rst_regwr",  {31'd0, cif.RegWrite}, 32'd0);
        chk("rst_pcwr0",  {31'd0, cif.PCWrite}, 32'd0);
        cycle();
        cif.NextPC = 1'b1;
        #1;
        chk("rst_pcwr1",  {31'd0, cif.PCWrite}, 32'd1);
        cycle();
        chk("rst_flags2", {28'd0, cif.Flags},  32'd0);

        reset_n    = 1'b1;
        cif.NextPC = 1'b0;
        cif.RegW   = 1'b0;
        cif.MemW   = 1'b0;
        cif.PCS    = 1'b0;

        // AL then full flag write
        drive(4'b1110, 1'b1, 2'b00, 4'h0);
        cycle();
        chk("al_condex", {31'd0, cif.CondEx}, 32'd1);
        drive(4'b1110, 1'b0, 2'b11, 4'b0100);
        cycle();
        chk("al_flags", {28'd0, cif.Flags}, 32'h4);

        // EQ taken with Z set
        decode_chk("eq_taken", 4'b0000, 1'b1);
        drive(4'b0000, 1'b0, 2'b00, 4'h0);
        cif.RegW = 1'b1;
        #1;
        chk("eq_regwr", {31'd0, cif.RegWrite}, 32'd1);
        cycle();

        // NE suppressed: all gated enables low
        decode_chk("ne_supp", 4'b0001, 1'b0);
        drive(4'b0001, 1'b0, 2'b00, 4'h0);
        cif.RegW = 1'b1; cif.MemW = 1'b1; cif.PCS = 1'b1; cif.NextPC = 1'b0;
        #1;
        chk("ne_regwr", {31'd0, cif.RegWrite}, 32'd0);
        chk("ne_memwr", {31'd0, cif.MemWrite}, 32'd0);
        chk("ne_pcwr",  {31'd0, cif.PCWrite},  32'd0);
        cycle();

        // Partial flag writes
        load_flags(4'b1111);
        chk("pf_full", {28'd0, cif.Flags}, 32'hF);
        drive(4'b1110, 1'b0, 2'b01, 4'b0000);
        cycle();
        chk("pf_cv", {28'd0, cif.Flags}, 32'hC);
        drive(4'b1110, 1'b0, 2'b10, 4'b0000);
        cycle();
        chk("pf_nz", {28'd0, cif.Flags}, 32'h0);

        // Suppressed instruction leaves flags alone
        decode_chk("rsv_zero", 4'b1111, 1'b0);
        drive(4'b1111, 1'b0, 2'b11, 4'b1010);
        cycle();
        chk("supp_flags", {28'd0, cif.Flags}, 32'h0);

        // Signed compares with N==V
        load_flags(4'b1001);
        decode_chk("ge", 4'b1010, 1'b1);
        decode_chk("lt", 4'b1011, 1'b0);
        decode_chk("gt", 4'b1100, 1'b1);
        decode_chk("le", 4'b1101, 1'b0);

        // Unsigned compares with only C set
        load_flags(4'b0010);
        decode_chk("hi", 4'b1000, 1'b1);
        decode_chk("ls", 4'b1001, 1'b0);
        decode_chk("rsv", 4'b1111, 1'b0);

        // Decode and flag write in the same cycle: CS sees the old C=1
        decode_chk("al_again", 4'b1110, 1'b1);
        drive(4'b0010, 1'b1, 2'b11, 4'b0000);
        cycle();
        chk("same_condex", {31'd0, cif.CondEx}, 32'd1);
        chk("same_flags",  {28'd0, cif.Flags},  32'h0);

        // Randomized traffic, with occasional resets
        for (int i = 0; i < 3000; i++) begin
            reset_n       = ($urandom_range(0, 19) != 0);
            cif.Cond      = 4'($urandom);
            cif.ALUFlags  = 4'($urandom);
            cif.FlagW     = 2'($urandom);
            cif.dec_valid = 1'($urandom);
            cif.PCS       = 1'($urandom);
            cif.NextPC    = 1'($urandom);
            cif.RegW      = 1'($urandom);
            cif.MemW      = 1'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
